onchip_mem_arbiter: RTL and testbench
=====================================

// Module: onchip_mem_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single-port 32-bit on-chip RAM (5120 words, 13-bit word address, byte enables)
//  between two Avalon-MM requesters: s0 = Nios data master, s1 = image stream writer/reader.
//  Accepts at most one access per cycle and drives the RAM port directly.
//  Returns read data to the issuing requester with fixed latency. Flags out-of-range addresses.
// PARAMETERS
//  ADDR_W     13     word address width of RAM and both requester ports
//  DEPTH      5120   implemented words; address >= DEPTH is out-of-range
//  ARB_MODE   0      0 = round-robin, 1 = fixed priority (s0 always wins)
// PORTS
//  clk             in   1       single clock for all logic
//  reset           in   1       synchronous, active-high reset
//  sN_address      in   ADDR_W  requester N word address (N = 0,1)
//  sN_read         in   1       requester N read request
//  sN_write        in   1       requester N write request
//  sN_byteenable   in   4       requester N byte lanes
//  sN_writedata    in   32      requester N write data
//  sN_waitrequest  out  1       1 = request not accepted this cycle
//  sN_readdata     out  32      read return data
//  sN_readdatavalid out 1       1-cycle pulse, sN_readdata valid
//  mem_address     out  ADDR_W  RAM address
//  mem_byteenable  out  4       RAM byte enables
//  mem_chipselect  out  1       RAM access strobe
//  mem_write       out  1       RAM write (qualified by mem_chipselect)
//  mem_writedata   out  32      RAM write data
//  mem_readdata    in   32      RAM read data, valid cycle after address issue
//  oob_error       out  1       sticky: an out-of-range access was accepted
// BEHAVIOUR
//  Reset (synchronous, active-high): last_grant <= s1 (so s0 wins first tie); rd pipeline cleared;
//   sN_readdata <= 0, sN_readdatavalid <= 0, oob_error <= 0. While reset = 1: both waitrequest = 1,
//   mem_chipselect = 0. A read in flight when reset asserts never returns readdatavalid.
//  Request: reqN = sN_read | sN_write. read & write together is illegal; treat it as a write.
//  Grant (combinational, same cycle): only one req -> that one. Both -> ARB_MODE 1: s0.
//   ARB_MODE 0: requester opposite last_grant. last_grant updates on every accepted access.
//  sN_waitrequest = ~grantN (high when idle or losing). Loser holds its signals until accepted.
//  Issue cycle T: mem_address/byteenable/writedata/write muxed from the grantee.
//   mem_chipselect = grant & in-range. Out-of-range: accepted, no RAM access, oob_error <= 1.
//   Out-of-range read returns 32'h0 on schedule.
//  Read pipeline: stage1 {valid,id,oob} registered at T; at T+1 sample mem_readdata (0 if oob)
//   into sN_readdata of id. sN_readdatavalid = 1 for exactly cycle T+2. Latency is fixed at 2.
//   Back-to-back reads stream one per cycle. Writes produce no response.
//  Read vs write ordering: a write accepted at T is seen by any read accepted at T+1 or later,
//   regardless of requester. RAM read-during-write at T is never exercised.
//  sN_readdata holds its last value when readdatavalid = 0.
//  Throughput: 1 access/cycle total. Round-robin bounds the wait of either requester to 1 cycle
//   under continuous contention.
// TESTING
//  1. After reset, s0 writes 0xA5A5_1234 @0x0010 with be=4'hF; s0 reads @0x0010
//     -> waitrequest low both cycles, s0_readdatavalid at T+2, data 0xA5A5_1234.
//  2. s0 writes 0xFFFF_FFFF @0x20; s1 writes 0x0000_00AB @0x20 with be=4'h1; s1 reads @0x20
//     -> 0xFFFF_FFAB.
//  3. Both read continuously, ARB_MODE 0 -> grants alternate s0,s1,s0,...
//     Each readdatavalid is routed to its issuer with that issuer's data.
//     ARB_MODE 1 -> s1 starves while s0 requests.
//  4. s1 reads @5120 (0x1400) -> accepted, mem_chipselect = 0, s1_readdata = 0 at T+2, oob_error = 1 and stays 1.
//  5. s0 reads @0x0004, reset asserted at T+1 -> no s0_readdatavalid. All outputs at reset values.
//     Next access after deassert is granted to s0 on a tie.
//  6. s0 write and s1 read @0x0030 in the same cycle (RR, s0 first) -> s1 waits 1 cycle
//     and reads the newly written value.

Source files
------------

// File: rtl/onchip_mem_arbiter.sv
// Two-requester arbiter for the single-port on-chip RAM: same-cycle grant, direct RAM drive,
// fixed two-cycle read return to the issuer, sticky out-of-range flag.
module onchip_mem_arbiter #(
    parameter int ADDR_W   = 13,
    parameter int DEPTH    = 5120,
    parameter int ARB_MODE = 0
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] s0_address,
    input  logic              s0_read,
    input  logic              s0_write,
    input  logic [3:0]        s0_byteenable,
    input  logic [31:0]       s0_writedata,
    output logic              s0_waitrequest,
    output logic [31:0]       s0_readdata,
    output logic              s0_readdatavalid,

    input  logic [ADDR_W-1:0] s1_address,
    input  logic              s1_read,
    input  logic              s1_write,
    input  logic [3:0]        s1_byteenable,
    input  logic [31:0]       s1_writedata,
    output logic              s1_waitrequest,
    output logic [31:0]       s1_readdata,
    output logic              s1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic [31:0]       mem_readdata,

    output logic              oob_error
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    logic              req0, req1;
    logic              grant0, grant1, grant_any;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_wr;
    logic              in_range;
    logic              rd_issue;

    // 1 = s1 was the most recent grantee
    logic              last_grant_q, last_grant_d;

    logic              rd_vld_p1_q, rd_id_p1_q, rd_oob_p1_q;
    logic              s0_rdv_p2_q, s1_rdv_p2_q;
    logic [31:0]       s0_rdata_p2_q, s1_rdata_p2_q;
    logic [31:0]       rdata_p1;
    logic              oob_q, oob_d;

    assign req0 = s0_read | s0_write;
    assign req1 = s1_read | s1_write;

    // Tie-break goes to the requester that was not served last; nothing is granted during reset.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            if (req0 && req1) begin
                if ((ARB_MODE == 1) || last_grant_q) begin
                    grant0 = 1'b1;
                end else begin
                    grant1 = 1'b1;
                end
            end else begin
                grant0 = req0;
                grant1 = req1;
            end
        end
    end

    assign grant_any      = grant0 | grant1;
    assign s0_waitrequest = ~grant0;
    assign s1_waitrequest = ~grant1;

    // A simultaneous read and write is handled as a write.
    always_comb begin
        if (grant1) begin
            sel_addr       = s1_address;
            sel_wr         = s1_write;
            mem_byteenable = s1_byteenable;
            mem_writedata  = s1_writedata;
        end else begin
            sel_addr       = s0_address;
            sel_wr         = s0_write;
            mem_byteenable = s0_byteenable;
            mem_writedata  = s0_writedata;
        end
    end

    assign in_range       = ({1'b0, sel_addr} < DEPTH_C);
    assign mem_address    = sel_addr;
    assign mem_chipselect = grant_any & in_range;
    assign mem_write      = grant_any & sel_wr;
    assign rd_issue       = grant_any & ~sel_wr;

    assign last_grant_d = grant_any ? grant1 : last_grant_q;
    assign oob_d        = oob_q | (grant_any & ~in_range);

    // Out-of-range reads return zero instead of whatever the RAM output holds.
    assign rdata_p1 = rd_oob_p1_q ? 32'h0 : mem_readdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            rd_vld_p1_q  <= 1'b0;
            oob_q        <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rd_vld_p1_q  <= rd_issue;
            oob_q        <= oob_d;
        end
    end

    // Stage 1: remember who issued the read and whether it was out of range.
    always_ff @(posedge clk) begin
        rd_id_p1_q  <= grant1;
        rd_oob_p1_q <= ~in_range;
    end

    // Stage 2: capture RAM data into the issuer's return register.
    always_ff @(posedge clk) begin
        if (reset) begin
            s0_rdv_p2_q   <= 1'b0;
            s1_rdv_p2_q   <= 1'b0;
            s0_rdata_p2_q <= 32'h0;
            s1_rdata_p2_q <= 32'h0;
        end else begin
            s0_rdv_p2_q <= rd_vld_p1_q & ~rd_id_p1_q;
            s1_rdv_p2_q <= rd_vld_p1_q & rd_id_p1_q;
            if (rd_vld_p1_q && !rd_id_p1_q) begin
                s0_rdata_p2_q <= rdata_p1;
            end
            if (rd_vld_p1_q && rd_id_p1_q) begin
                s1_rdata_p2_q <= rdata_p1;
            end
        end
    end

    assign s0_readdata      = s0_rdata_p2_q;
    assign s0_readdatavalid = s0_rdv_p2_q;
    assign s1_readdata      = s1_rdata_p2_q;
    assign s1_readdatavalid = s1_rdv_p2_q;
    assign oob_error        = oob_q;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: behavioural RAM, shadow memory, per-requester read scoreboards,
// a vector table for single-cycle accesses and hand sequences for contention and reset.
module tb_onchip_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic [12:0] s0_address, s1_address;
    logic        s0_read, s0_write, s1_read, s1_write;
    logic [3:0]  s0_byteenable, s1_byteenable;
    logic [31:0] s0_writedata, s1_writedata;
    logic        s0_waitrequest, s1_waitrequest, s0_readdatavalid, s1_readdatavalid;
    logic [31:0] s0_readdata, s1_readdata;
    logic [12:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata = 32'h0;
    logic        oob_error;

    logic        f_s0_wait, f_s1_wait, f_s0_rdv, f_s1_rdv, f_cs, f_we, f_oob;
    logic [31:0] f_s0_rd, f_s1_rd, f_wd;
    logic [12:0] f_addr;
    logic [3:0]  f_be;
    logic [31:0] f_mem_rd = 32'h0;

    onchip_mem_arbiter #(.ADDR_W(13), .DEPTH(5120), .ARB_MODE(0)) dut (
        .clk(clk), .reset(reset),
        .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
        .s0_byteenable(s0_byteenable), .s0_writedata(s0_writedata),
        .s0_waitrequest(s0_waitrequest), .s0_readdata(s0_readdata), .s0_readdatavalid(s0_readdatavalid),
        .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
        .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .oob_error(oob_error)
    );

    onchip_mem_arbiter #(.ADDR_W(13), .DEPTH(5120), .ARB_MODE(1)) dut_fixed (
        .clk(clk), .reset(reset),
        .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
        .s0_byteenable(s0_byteenable), .s0_writedata(s0_writedata),
        .s0_waitrequest(f_s0_wait), .s0_readdata(f_s0_rd), .s0_readdatavalid(f_s0_rdv),
        .s1_address(s1_address), .s1_read(s1_read), .s1_write(s1_write),
        .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_waitrequest(f_s1_wait), .s1_readdata(f_s1_rd), .s1_readdatavalid(f_s1_rdv),
        .mem_address(f_addr), .mem_byteenable(f_be), .mem_chipselect(f_cs),
        .mem_write(f_we), .mem_writedata(f_wd), .mem_readdata(f_mem_rd),
        .oob_error(f_oob)
    );

    // Synchronous RAM: data for an address issued at T appears during T+1.
    logic [31:0] ram [0:5119];
    always @(posedge clk) begin
        if (mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram[int'(mem_address)][8*b +: 8] <= mem_writedata[8*b +: 8];
            end
            mem_readdata <= ram[int'(mem_address)];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    typedef struct {
        logic        r0, w0;
        logic [12:0] a0;
        logic [3:0]  b0;
        logic [31:0] d0;
        logic        r1, w1;
        logic [12:0] a1;
        logic [3:0]  b1;
        logic [31:0] d1;
        logic        ew0, ew1, ecs, eoob;
        logic [31:0] erd0, erd1;
    } vec_t;

    exp_t        q0[$], q1[$];
    logic [31:0] shadow [0:8191];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        use_tbl = 1'b0;
    logic [31:0] tbl_e0, tbl_e1;
    vec_t        tbl [10];
    vec_t        v;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Read returns: each valid must match the oldest outstanding read of that requester, two cycles on.
    always @(negedge clk) begin
        exp_t e;
        if (s0_readdatavalid) begin
            if (q0.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL s0_unexpected_rdv: got valid=1 expected 0 at cycle %0d", cyc);
            end else begin
                e = q0.pop_front();
                chk32("s0_rdata", s0_readdata, e.data);
                chk32("s0_latency", 32'(cyc), 32'(e.cyc + 2));
            end
        end
        if (s1_readdatavalid) begin
            if (q1.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL s1_unexpected_rdv: got valid=1 expected 0 at cycle %0d", cyc);
            end else begin
                e = q1.pop_front();
                chk32("s1_rdata", s1_readdata, e.data);
                chk32("s1_latency", 32'(cyc), 32'(e.cyc + 2));
            end
        end
    end

    task automatic drive(input vec_t x);
        s0_read = x.r0; s0_write = x.w0; s0_address = x.a0; s0_byteenable = x.b0; s0_writedata = x.d0;
        s1_read = x.r1; s1_write = x.w1; s1_address = x.a1; s1_byteenable = x.b1; s1_writedata = x.d1;
    endtask

    task automatic record(input int id, input logic wr, input logic [12:0] a, input logic [3:0] be,
                          input logic [31:0] wd, input logic [31:0] texp);
        exp_t e;
        if (wr) begin
            if (a < 13'd5120)
                for (int b = 0; b < 4; b++) if (be[b]) shadow[a][8*b +: 8] = wd[8*b +: 8];
        end else begin
            e.cyc  = cyc;
            e.data = use_tbl ? texp : ((a >= 13'd5120) ? 32'h0 : shadow[a]);
            if (id == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    // Called at a negative edge: log accepted accesses, then move to just after the next rising edge.
    task automatic accept_and_advance();
        if (!reset && (s0_read || s0_write) && !s0_waitrequest)
            record(0, s0_write, s0_address, s0_byteenable, s0_writedata, tbl_e0);
        if (!reset && (s1_read || s1_write) && !s1_waitrequest)
            record(1, s1_write, s1_address, s1_byteenable, s1_writedata, tbl_e1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        vec_t z;
        z = '{1'b0, 1'b0, 13'h0, 4'h0, 32'h0, 1'b0, 1'b0, 13'h0, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
        drive(z);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            accept_and_advance();
        end
    endtask

    initial begin
        for (int i = 0; i < 5120; i++) ram[i] = 32'h0;
        for (int i = 0; i < 8192; i++) shadow[i] = 32'h0;

        //            r0 w0 a0        b0    d0            r1 w1 a1        b1    d1            w0 w1 cs oob erd0          erd1
        tbl[0] = '{1'b0, 1'b1, 13'h0010, 4'hF, 32'hA5A51234, 1'b0, 1'b0, 13'h0000, 4'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0};
        tbl[1] = '{1'b1, 1'b0, 13'h0010, 4'hF, 32'h0,        1'b0, 1'b0, 13'h0000, 4'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hA5A51234, 32'h0};
        tbl[2] = '{1'b0, 1'b1, 13'h0020, 4'hF, 32'hFFFFFFFF, 1'b0, 1'b0, 13'h0000, 4'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0};
        tbl[3] = '{1'b0, 1'b0, 13'h0000, 4'h0, 32'h0,        1'b0, 1'b1, 13'h0020, 4'h1, 32'h000000AB, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0};
        tbl[4] = '{1'b0, 1'b0, 13'h0000, 4'h0, 32'h0,        1'b1, 1'b0, 13'h0020, 4'hF, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'hFFFFFFAB};
        tbl[5] = '{1'b0, 1'b0, 13'h0000, 4'h0, 32'h0,        1'b1, 1'b0, 13'h1400, 4'hF, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0};
        tbl[6] = '{1'b1, 1'b0, 13'h0010, 4'hF, 32'h0,        1'b1, 1'b0, 13'h0020, 4'hF, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'hA5A51234, 32'h0};
        tbl[7] = '{1'b0, 1'b0, 13'h0000, 4'h0, 32'h0,        1'b1, 1'b0, 13'h0020, 4'hF, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'hFFFFFFAB};
        tbl[8] = '{1'b0, 1'b0, 13'h0000, 4'h0, 32'h0,        1'b0, 1'b0, 13'h0000, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0};
        tbl[9] = '{1'b0, 1'b0, 13'h0000, 4'h0, 32'h0,        1'b0, 1'b0, 13'h0000, 4'h0, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0};

        // Reset with requests pending: nothing may be granted or reach the RAM.
        reset = 1'b1;
        v = tbl[6];
        drive(v);
        @(negedge clk);
        @(negedge clk);
        chk1("rst_s0_wait", s0_waitrequest, 1'b1);
        chk1("rst_s1_wait", s1_waitrequest, 1'b1);
        chk1("rst_cs", mem_chipselect, 1'b0);
        chk1("rst_s0_rdv", s0_readdatavalid, 1'b0);
        chk1("rst_s1_rdv", s1_readdatavalid, 1'b0);
        chk32("rst_s0_rdata", s0_readdata, 32'h0);
        chk32("rst_s1_rdata", s1_readdata, 32'h0);
        chk1("rst_oob", oob_error, 1'b0);
        idle_cycles(1);
        reset = 1'b0;
        idle_cycles(1);

        use_tbl = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i]);
            tbl_e0 = tbl[i].erd0;
            tbl_e1 = tbl[i].erd1;
            @(negedge clk);
            chk1($sformatf("v%0d_s0_wait", i), s0_waitrequest, tbl[i].ew0);
            chk1($sformatf("v%0d_s1_wait", i), s1_waitrequest, tbl[i].ew1);
            chk1($sformatf("v%0d_cs", i), mem_chipselect, tbl[i].ecs);
            chk1($sformatf("v%0d_oob", i), oob_error, tbl[i].eoob);
            accept_and_advance();
        end
        use_tbl = 1'b0;

        // Continuous contention: round-robin alternates starting with s0, fixed priority starves s1.
        v = tbl[6];
        drive(v);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk1($sformatf("rr%0d_s0_wait", i), s0_waitrequest, (i % 2) == 1);
            chk1($sformatf("rr%0d_s1_wait", i), s1_waitrequest, (i % 2) == 0);
            chk1($sformatf("fix%0d_s0_wait", i), f_s0_wait, 1'b0);
            chk1($sformatf("fix%0d_s1_wait", i), f_s1_wait, 1'b1);
            accept_and_advance();
        end
        idle_cycles(3);

        // Write and read of the same word collide: the read waits and sees the new data.
        v = '{1'b0, 1'b1, 13'h0030, 4'hF, 32'h12345678, 1'b1, 1'b0, 13'h0030, 4'hF, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0};
        drive(v);
        @(negedge clk);
        chk1("wr_rd_s0_wait", s0_waitrequest, 1'b0);
        chk1("wr_rd_s1_wait", s1_waitrequest, 1'b1);
        chk1("wr_rd_we", mem_write, 1'b1);
        accept_and_advance();
        v.w0 = 1'b0;
        drive(v);
        @(negedge clk);
        chk1("wr_rd_s1_wait2", s1_waitrequest, 1'b0);
        chk1("wr_rd_we2", mem_write, 1'b0);
        accept_and_advance();
        idle_cycles(3);
        chk32("wr_rd_s1_data", s1_readdata, 32'h12345678);
        chk32("s0_rdata_hold", s0_readdata, 32'hA5A51234);

        // Reset lands while a read is in flight: its return is dropped and state reinitialises.
        v = '{1'b1, 1'b0, 13'h0004, 4'hF, 32'h0, 1'b0, 1'b0, 13'h0, 4'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0};
        drive(v);
        @(negedge clk);
        chk1("rif_s0_wait", s0_waitrequest, 1'b0);
        accept_and_advance();
        reset = 1'b1;
        q0.delete();
        q1.delete();
        v = tbl[6];
        drive(v);
        @(negedge clk);
        chk1("rif_rst_s0_wait", s0_waitrequest, 1'b1);
        chk1("rif_rst_s1_wait", s1_waitrequest, 1'b1);
        chk1("rif_rst_cs", mem_chipselect, 1'b0);
        accept_and_advance();
        @(negedge clk);
        chk1("rif_s0_rdv", s0_readdatavalid, 1'b0);
        chk32("rif_s0_rdata", s0_readdata, 32'h0);
        chk32("rif_s1_rdata", s1_readdata, 32'h0);
        chk1("rif_oob_cleared", oob_error, 1'b0);
        accept_and_advance();
        reset = 1'b0;
        @(negedge clk);
        chk1("post_rst_s0_wait", s0_waitrequest, 1'b0);
        chk1("post_rst_s1_wait", s1_waitrequest, 1'b1);
        accept_and_advance();
        @(negedge clk);
        chk1("post_rst_s1_wait2", s1_waitrequest, 1'b0);
        accept_and_advance();
        idle_cycles(4);

        chk32("q0_drained", 32'(q0.size()), 32'h0);
        chk32("q1_drained", 32'(q1.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
